comparator_seq: RTL

- Multi-cycle, parametrised magnitude comparator for the datapath, successor to the single-cycle comparator_eq/comparator_lt pair.
- Scans operands MSB-first, CHUNK bits per cycle, and terminates early on the first differing chunk.
- Supports signed or unsigned ordering, selected per transaction.
- Reports equal / less_than / greater_than over a valid/ready handshake; sits between operand registers and branch/ALU-flag consumers.

---
 rtl/comparator_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle magnitude comparator.
//
// Scans the latched operands MSB-first, CHUNK bits per cycle, and stops on
// the first chunk that differs. Signed ordering is handled by flipping the
// sign bit of both operands at accept time, which maps two's-complement
// order onto plain unsigned order so that every chunk compare is unsigned.
//
// Ports:
//   clk          clock, rising-edge active
//   rst          asynchronous active-high reset
//   i_valid      operands/mode presented (sampled only in IDLE)
//   i_ready      block can accept a transaction (IDLE only)
//   a, b         N-bit operands
//   signed_mode  1 = two's-complement ordering, 0 = unsigned ordering
//   o_valid      result available (held through backpressure)
//   o_ready      consumer takes the result
//   equal        a == b
//   less_than    a <  b under the selected ordering
//   greater_than a >  b under the selected ordering
module comparator_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         equal,
  output logic         less_than,
  output logic         greater_than
);

  localparam int NUM_CHUNKS = N / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [N-1:0]     a_r, a_s;
  logic [N-1:0]     b_r, b_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             i_ready_r, i_ready_s;
  logic             o_valid_r, o_valid_s;
  logic             equal_r, equal_s;
  logic             less_r, less_s;
  logic             greater_r, greater_s;

  // Operands are shifted left after each equal chunk, so the chunk under
  // test always sits in the top CHUNK bits of the working registers.
  logic [CHUNK-1:0] chunk_a_s, chunk_b_s;
  logic [N-1:0]     a_shift_s, b_shift_s;

  assign chunk_a_s = a_r[N-1 -: CHUNK];
  assign chunk_b_s = b_r[N-1 -: CHUNK];

  generate
    if (NUM_CHUNKS > 1) begin : g_shift
      assign a_shift_s = {a_r[N-CHUNK-1:0], {CHUNK{1'b0}}};
      assign b_shift_s = {b_r[N-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_noshift
      assign a_shift_s = a_r;
      assign b_shift_s = b_r;
    end
  endgenerate

  // Next-state and next-output logic for the compare FSM.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    idx_s     = idx_r;
    i_ready_s = i_ready_r;
    o_valid_s = o_valid_r;
    equal_s   = equal_r;
    less_s    = less_r;
    greater_s = greater_r;

    case (state_r)
      IDLE: begin
        if (i_valid && i_ready_r) begin
          state_s   = COMPARE;
          a_s       = a;
          b_s       = b;
          idx_s     = IDX_ZERO;
          i_ready_s = 1'b0;
          o_valid_s = 1'b0;
          equal_s   = 1'b0;
          less_s    = 1'b0;
          greater_s = 1'b0;
          // Flipping the sign bit turns two's-complement order into
          // unsigned order for the whole scan.
          if (signed_mode) begin
            a_s[N-1] = ~a[N-1];
            b_s[N-1] = ~b[N-1];
          end else begin
            a_s[N-1] = a[N-1];
            b_s[N-1] = b[N-1];
          end
        end else begin
          i_ready_s = 1'b1;
        end
      end

      COMPARE: begin
        if (chunk_a_s != chunk_b_s) begin
          less_s    = (chunk_a_s < chunk_b_s);
          greater_s = (chunk_a_s > chunk_b_s);
          o_valid_s = 1'b1;
          state_s   = DONE;
        end else if (idx_r == LAST_IDX) begin
          equal_s   = 1'b1;
          o_valid_s = 1'b1;
          state_s   = DONE;
        end else begin
          idx_s = idx_r + IDX_ONE;
          a_s   = a_shift_s;
          b_s   = b_shift_s;
        end
      end

      DONE: begin
        // Flags are left as-is on release; only the next accept clears them.
        if (o_ready) begin
          o_valid_s = 1'b0;
          i_ready_s = 1'b1;
          state_s   = IDLE;
        end else begin
          o_valid_s = 1'b1;
        end
      end

      default: begin
        state_s   = IDLE;
        i_ready_s = 1'b1;
        o_valid_s = 1'b0;
        equal_s   = 1'b0;
        less_s    = 1'b0;
        greater_s = 1'b0;
      end
    endcase
  end

  // State, working operands, chunk index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      idx_r     <= IDX_ZERO;
      i_ready_r <= 1'b1;
      o_valid_r <= 1'b0;
      equal_r   <= 1'b0;
      less_r    <= 1'b0;
      greater_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      idx_r     <= idx_s;
      i_ready_r <= i_ready_s;
      o_valid_r <= o_valid_s;
      equal_r   <= equal_s;
      less_r    <= less_s;
      greater_r <= greater_s;
    end
  end

  assign i_ready      = i_ready_r;
  assign o_valid      = o_valid_r;
  assign equal        = equal_r;
  assign less_than    = less_r;
  assign greater_than = greater_r;

endmodule
